div_seq_32bit: RTL and testbench
================================

Name: div_seq_32bit

Overview:
- Multi-cycle 32-bit integer divider controller for the MiniMIPS ALU.
- Sequences one shared 33-bit restore-subtract step per clock: 32 iterations produce quotient and remainder.
- Sits beside the combinational ALU. Execute stage issues `start` and stalls on `busy` until `done` pulses (DIV/DIVU → HI/LO).

Parameters:
- WIDTH, 32, operand/result width. Iteration count equals WIDTH. Only 32 is verified.

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- is_signed  input  1  1 = signed divide (used only with DIV_SIGNED_EN)
- dividend  input  32  numerator; sampled on the accepted start edge
- divisor  input  32  denominator; sampled on the accepted start edge
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse; results valid
- quotient  output  32  registered quotient
- remainder  output  32  registered remainder
- div_by_zero  output  1  set with done when divisor == 0
- overflow  output  1  set with done on signed 0x80000000 / -1

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high.
  - Reset has priority over everything, including mid-operation.
  - Reset forces state = IDLE and clears count.
  - Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0.
  - An aborted operation produces no done.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - start=1 latches the operands and clears the flags.
  - divisor != 0: rem_acc=0, q_acc=|dividend|, count=0, go to RUN.
  - divisor == 0: go directly to FIN with quotient=32'hFFFFFFFF, remainder=dividend, div_by_zero=1.
- RUN:
  - busy=1.
  - Each edge: shifted = {rem_acc, q_acc[31]} (33 bits); diff = shifted - {1'b0, |divisor|}.
  - diff[32]==0: rem_acc=diff[31:0], q_acc={q_acc[30:0],1}.
  - Otherwise: rem_acc=shifted[31:0], q_acc={q_acc[30:0],0}.
  - count increments each edge. After the 32nd step (count wraps from 31), go to FIN and load quotient/remainder.
- FIN:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
- Latency:
  - start accepted at edge N → done high after edge N+33 (N+1 for divide-by-zero).
  - busy is high after edges N+1..N+32.
- start while busy or in FIN is ignored. No queuing. Operands may change freely after the accepting edge.
- quotient, remainder and the flags hold their values until the next accepted start or reset.
- A new start is accepted in the IDLE cycle immediately after the done pulse (back-to-back, 34-cycle cadence).
- Unsigned arithmetic is modulo 2^32. The 33rd diff bit serves as borrow, so no overflow from the subtract step.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined, when is_signed=1:
  - Operands are converted to magnitudes at load.
  - At FIN, quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF bypasses RUN (latency 1): quotient=0x80000000, remainder=0, overflow=1.
  - Signed divide-by-zero: quotient = (dividend<0) ? 1 : 32'hFFFFFFFF, remainder=dividend.
- Not defined: is_signed is ignored, all divides are unsigned, and overflow is held 0.
- Latency is identical in both builds.

Test Plan:
- Reset, then start with dividend=222222, divisor=200000 → done pulse exactly 33 cycles later; quotient=1, remainder=22222, flags 0.
- dividend=199999999, divisor=1 → quotient=199999999, remainder=0. Back-to-back: dividend=1, divisor=2 issued the cycle after done → quotient=0, remainder=1.
- dividend=90000000, divisor=0 → done after 1 cycle; div_by_zero=1, quotient=32'hFFFFFFFF, remainder=90000000.
- Start with 98888888/10000091; pulse start again with 5/1 at cycle 10 → second start ignored; result quotient=9, remainder=8888069.
- Start 0xFFFFFFFE/0x55555555, assert reset at cycle 15 → no done pulse; all outputs 0; a following 100000000/200000000 gives quotient=0, remainder=100000000.
- DIV_SIGNED_EN, is_signed=1: -7/2 → quotient=32'hFFFFFFFD, remainder=32'hFFFFFFFF. 0x80000000/0xFFFFFFFF → quotient=0x80000000, remainder=0, overflow=1 after 1 cycle.

Source files
------------

// File: rtl/div_seq_32bit.sv
// div_seq_32bit: multi-cycle restoring divider, one quotient bit per clock.
// Optional signed support is compiled in with `define DIV_SIGNED_EN.
// Without it, is_signed is ignored, every divide is unsigned and overflow stays 0.
module div_seq_32bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rem_acc_q, rem_acc_d;
  logic [WIDTH-1:0] q_acc_q, q_acc_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;       // divisor magnitude
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;
  logic             neg_q_q, neg_q_d;   // negate quotient at finish
  logic             neg_r_q, neg_r_d;   // negate remainder at finish

  logic             sgn;
  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   shifted, diff;

`ifdef DIV_SIGNED_EN
  assign sgn = is_signed;
`else
  // Unsigned-only build: is_signed is intentionally left unconnected.
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
  assign sgn = 1'b0;
`endif

  assign dvd_neg = sgn & dividend[WIDTH-1];
  assign dvs_neg = sgn & divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dvs_mag = dvs_neg ? -divisor  : divisor;

  // The 33rd bit of diff is the borrow: set means the divisor did not fit.
  assign shifted = {rem_acc_q, q_acc_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  // Next-state and datapath: load in IDLE, one restore step per RUN cycle.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rem_acc_d = rem_acc_q;
    q_acc_d   = q_acc_q;
    dvs_d     = dvs_q;
    quo_d     = quo_q;
    rmd_d     = rmd_q;
    dbz_d     = dbz_q;
    ovf_d     = ovf_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          neg_q_d = dvd_neg ^ dvs_neg;
          neg_r_d = dvd_neg;
          if (divisor == '0) begin
            quo_d   = dvd_neg ? WIDTH'(1) : '1;
            rmd_d   = dividend;
            dbz_d   = 1'b1;
            state_d = FIN;
          end else if (sgn && dividend == {1'b1, {(WIDTH-1){1'b0}}} && divisor == '1) begin
            // Most-negative / -1 does not fit; report it without iterating.
            quo_d   = dividend;
            rmd_d   = '0;
            ovf_d   = 1'b1;
            state_d = FIN;
          end else begin
            rem_acc_d = '0;
            q_acc_d   = dvd_mag;
            dvs_d     = dvs_mag;
            count_d   = '0;
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        if (!diff[WIDTH]) begin
          rem_acc_d = diff[WIDTH-1:0];
          q_acc_d   = {q_acc_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_acc_d = shifted[WIDTH-1:0];
          q_acc_d   = {q_acc_q[WIDTH-2:0], 1'b0};
        end
        count_d = count_q + 1'b1;
        if (count_q == CW'(WIDTH-1)) begin
          quo_d   = neg_q_q ? -q_acc_d   : q_acc_d;
          rmd_d   = neg_r_q ? -rem_acc_d : rem_acc_d;
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset wins over any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      rem_acc_q <= '0;
      q_acc_q   <= '0;
      dvs_q     <= '0;
      quo_q     <= '0;
      rmd_q     <= '0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rem_acc_q <= rem_acc_d;
      q_acc_q   <= q_acc_d;
      dvs_q     <= dvs_d;
      quo_q     <= quo_d;
      rmd_q     <= rmd_d;
      dbz_q     <= dbz_d;
      ovf_q     <= ovf_d;
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == FIN);
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_div_seq_32bit.sv
// Scoreboard bench for div_seq_32bit: stimulus pushes expected results,
// a negedge monitor pops and checks them whenever done pulses.
module tb_div_seq_32bit;

  logic        clk = 1'b0;
  logic        reset, start, is_signed;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_by_zero, overflow;
  logic [31:0] quotient, remainder;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  div_seq_32bit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient",    quotient,            e.q);
        chk("remainder",   remainder,           e.r);
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
        chk("overflow",    {31'd0, overflow},    {31'd0, e.ovf});
        chk("done_cycle",  cyc,                 e.cyc);
        chk("busy_at_done", {31'd0, busy},       32'd0);
      end
    end
  end

  // Caller sits just after a rising edge; start is sampled on the next edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] eq, input logic [31:0] er,
                       input logic edbz, input logic eovf, input int lat, input bit push);
    exp_t e;
    #1;
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    if (push) begin
      e.q = eq; e.r = er; e.dbz = edbz; e.ovf = eovf; e.cyc = cyc + lat;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 32'hA5A5_5A5A;   // operands are free to change after acceptance
    divisor  = 32'h0000_0003;
    chk("busy_after_start", {31'd0, busy}, {31'd0, (lat != 1)});
  endtask

  // Returns just after the rising edge following the last done pulse.
  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quot", quotient, 32'd0);
    chk("rst_rem",  remainder, 32'd0);
    chk("rst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
    reset = 1'b0;
    @(posedge clk);

    issue(32'd222222, 32'd200000, 1'b0, 32'd1, 32'd22222, 1'b0, 1'b0, 33, 1'b1);
    wait_done();

    // Back-to-back: second start lands in the IDLE cycle right after done.
    issue(32'd199999999, 32'd1, 1'b0, 32'd199999999, 32'd0, 1'b0, 1'b0, 33, 1'b1);
    wait_done();
    issue(32'd1, 32'd2, 1'b0, 32'd0, 32'd1, 1'b0, 1'b0, 33, 1'b1);
    wait_done();

    issue(32'd90000000, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd90000000, 1'b1, 1'b0, 1, 1'b1);
    wait_done();

    // A start pulsed mid-operation must be ignored.
    issue(32'd98888888, 32'd10000091, 1'b0, 32'd9, 32'd8888069, 1'b0, 1'b0, 33, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    dividend = 32'd5; divisor = 32'd1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();

    issue(32'hFFFF_FFFF, 32'h0000_0010, 1'b0, 32'h0FFF_FFFF, 32'h0000_000F, 1'b0, 1'b0, 33, 1'b1);
    wait_done();

    // Abort mid-run with reset: no done, outputs cleared.
    issue(32'hFFFF_FFFE, 32'h5555_5555, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 33, 1'b0);
    repeat (13) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_quot", quotient, 32'd0);
    chk("abort_rem",  remainder, 32'd0);
    chk("abort_flags", {30'd0, div_by_zero, overflow}, 32'd0);
    repeat (40) @(posedge clk);
    issue(32'd100000000, 32'd200000000, 1'b0, 32'd0, 32'd100000000, 1'b0, 1'b0, 33, 1'b1);
    wait_done();

`ifdef DIV_SIGNED_EN
    issue(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 33, 1'b1);
    wait_done();
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 1, 1'b1);
    wait_done();
    issue(32'hFFFF_FFF9, 32'd0, 1'b1, 32'd1, 32'hFFFF_FFF9, 1'b1, 1'b0, 1, 1'b1);
    wait_done();
`else
    // is_signed has no effect: these are plain unsigned divides.
    issue(32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0, 1'b0, 33, 1'b1);
    wait_done();
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0, 1'b0, 33, 1'b1);
    wait_done();
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
